// File: rtl/dmem_io_ctrl.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// dmem_io_ctrl
// Data memory plus memory-mapped I/O for the processor datapath.
//   - Block-RAM friendly data memory: registered read port, per-byte write
//     enables, read-during-write to the same word returns the old contents.
//   - I/O registers in the 0xFFFFxxxx region: HEX (16 bits shown on four
//     seven-segment digits), LEDR, LEDG, debounced KEY/SW data and their
//     sticky edge-capture control registers (RDY/OVR/IE) that drive IRQ.
//
// Ports
//   CLK, RESET     clock, asynchronous active-high reset
//   ADDRIN         byte address
//   DIN, WE, BE    write data, write enable, byte enables (memory only)
//   DOUT           read data, registered (valid one cycle after ADDRIN)
//   SW, KEY        raw switch / key pins (KEY active-low)
//   LEDR, LEDG     LED registers
//   HEX0..HEX3     active-low seven-segment digits of HexOut[15:0]
//   IRQ            registered interrupt request
// -----------------------------------------------------------------------------
module dmem_io_ctrl #(
   parameter int             DBITS     = 32,
   parameter int             DMEMWORDS = 2048,
   parameter int             ADDRBITS  = 13,
   parameter int             WORDBITS  = 2,
   parameter                 INITFILE  = "DataMem.mif",
   parameter int             NUMKEY    = 4,
   parameter int             NUMSW     = 10,
   parameter int             NUMLEDR   = 10,
   parameter int             NUMLEDG   = 8,
   parameter int             DEBOUNCE  = 50000,
   parameter logic [DBITS-1:0] ADDRHEX   = 32'hFFFF0000,
   parameter logic [DBITS-1:0] ADDRLEDR  = 32'hFFFF0020,
   parameter logic [DBITS-1:0] ADDRLEDG  = 32'hFFFF0040,
   parameter logic [DBITS-1:0] ADDRKDATA = 32'hFFFF0100,
   parameter logic [DBITS-1:0] ADDRKCTRL = 32'hFFFF0104,
   parameter logic [DBITS-1:0] ADDRSDATA = 32'hFFFF0120,
   parameter logic [DBITS-1:0] ADDRSCTRL = 32'hFFFF0124
) (
   input  logic                 CLK,
   input  logic                 RESET,
   input  logic [DBITS-1:0]     ADDRIN,
   input  logic [DBITS-1:0]     DIN,
   input  logic                 WE,
   input  logic [DBITS/8-1:0]   BE,
   output logic [DBITS-1:0]     DOUT,
   input  logic [NUMSW-1:0]     SW,
   input  logic [NUMKEY-1:0]    KEY,
   output logic [NUMLEDR-1:0]   LEDR,
   output logic [NUMLEDG-1:0]   LEDG,
   output logic [6:0]           HEX0,
   output logic [6:0]           HEX1,
   output logic [6:0]           HEX2,
   output logic [6:0]           HEX3,
   output logic                 IRQ
);

   localparam int NBYTES = DBITS / 8;
   localparam int NIN    = NUMKEY + NUMSW;
   localparam int CNTW   = (DEBOUNCE > 2) ? $clog2(DEBOUNCE) : 1;
   localparam int WIDX   = ADDRBITS - WORDBITS;

   // Active-low seven-segment encoding, segment order {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seven_seg(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'h0: s = 7'b1000000;
         4'h1: s = 7'b1111001;
         4'h2: s = 7'b0100100;
         4'h3: s = 7'b0110000;
         4'h4: s = 7'b0011001;
         4'h5: s = 7'b0010010;
         4'h6: s = 7'b0000010;
         4'h7: s = 7'b1111000;
         4'h8: s = 7'b0000000;
         4'h9: s = 7'b0010000;
         4'hA: s = 7'b0001000;
         4'hB: s = 7'b0000011;
         4'hC: s = 7'b1000110;
         4'hD: s = 7'b0100001;
         4'hE: s = 7'b0000110;
         default: s = 7'b0001110;
      endcase
      return s;
   endfunction

   function automatic logic [DBITS-1:0] ctrl_word(input logic rdy, input logic ovr,
                                                  input logic ie);
      logic [DBITS-1:0] w;
      w    = '0;
      w[0] = rdy;
      w[2] = ovr;
      w[8] = ie;
      return w;
   endfunction

   // ---------------------------------------------------------------- decode
   logic            is_io;
   logic [WIDX-1:0] widx;
   logic            wr_mem, wr_hex, wr_ledr, wr_ledg, wr_kctrl, wr_sctrl;

   assign is_io    = &ADDRIN[DBITS-1:16];
   // Upper address bits are not decoded, so memory aliases every 2^ADDRBITS.
   assign widx     = ADDRIN[ADDRBITS-1:WORDBITS];
   assign wr_mem   = WE && !is_io;
   assign wr_hex   = WE && (ADDRIN == ADDRHEX);
   assign wr_ledr  = WE && (ADDRIN == ADDRLEDR);
   assign wr_ledg  = WE && (ADDRIN == ADDRLEDG);
   assign wr_kctrl = WE && (ADDRIN == ADDRKCTRL);
   assign wr_sctrl = WE && (ADDRIN == ADDRSCTRL);

   // ---------------------------------------------------------------- memory
   // No reset on the array or its read register so this maps onto block RAM.
   logic [DBITS-1:0] mem [0:DMEMWORDS-1];
   logic [DBITS-1:0] mem_rd_q;

   always_ff @(posedge CLK) begin
      if (wr_mem) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (BE[b]) mem[widx][8*b +: 8] <= DIN[8*b +: 8];
         end
      end
      mem_rd_q <= mem[widx];
   end

   // ---------------------------------------------------- input conditioning
   // Keys are inverted up front so every conditioned bit reads 1 = active.
   logic [NIN-1:0]  raw;
   logic [NIN-1:0]  sync1_q, sync2_q, deb_q, deb_d, upd;
   logic [CNTW-1:0] cnt_q [NIN];
   logic [CNTW-1:0] cnt_d [NIN];

   assign raw = {SW, ~KEY};

   always_comb begin
      deb_d = deb_q;
      upd   = '0;
      for (int i = 0; i < NIN; i++) begin
         cnt_d[i] = cnt_q[i];
         if (sync2_q[i] == deb_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNTW'(DEBOUNCE - 1)) begin
            deb_d[i] = sync2_q[i];
            upd[i]   = 1'b1;
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNTW'(1);
         end
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         sync1_q <= '0;
         sync2_q <= '0;
         deb_q   <= '0;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= '0;
      end else begin
         sync1_q <= raw;
         sync2_q <= sync1_q;
         deb_q   <= deb_d;
         for (int i = 0; i < NIN; i++) cnt_q[i] <= cnt_d[i];
      end
   end

   logic [NUMKEY-1:0] key_deb;
   logic [NUMSW-1:0]  sw_deb;
   logic              key_ev, sw_ev;

   assign key_deb = deb_q[NUMKEY-1:0];
   assign sw_deb  = deb_q[NIN-1:NUMKEY];
   // Keys only report presses; switches report changes in either direction.
   assign key_ev  = |(upd[NUMKEY-1:0] & sync2_q[NUMKEY-1:0]);
   assign sw_ev   = |upd[NIN-1:NUMKEY];

   // ------------------------------------------------- edge-capture control
   logic krdy_q, kovr_q, kie_q, krdy_d, kovr_d, kie_d;
   logic srdy_q, sovr_q, sie_q, srdy_d, sovr_d, sie_d;

   // Events are applied after the write so a coincident event is never lost.
   always_comb begin
      krdy_d = krdy_q;
      kovr_d = kovr_q;
      kie_d  = kie_q;
      srdy_d = srdy_q;
      sovr_d = sovr_q;
      sie_d  = sie_q;
      if (wr_kctrl) begin
         krdy_d = krdy_q & DIN[0];
         kovr_d = kovr_q & DIN[2];
         kie_d  = DIN[8];
      end
      if (key_ev) begin
         krdy_d = 1'b1;
         if (krdy_q) kovr_d = 1'b1;
      end
      if (wr_sctrl) begin
         srdy_d = srdy_q & DIN[0];
         sovr_d = sovr_q & DIN[2];
         sie_d  = DIN[8];
      end
      if (sw_ev) begin
         srdy_d = 1'b1;
         if (srdy_q) sovr_d = 1'b1;
      end
   end

   // ------------------------------------------------------- I/O registers
   logic [15:0]        hex_q;
   logic [NUMLEDR-1:0] ledr_q;
   logic [NUMLEDG-1:0] ledg_q;
   logic [DBITS-1:0]   io_rdata, io_rd_q;
   logic               sel_io_q, irq_q;

   always_comb begin
      io_rdata = '0;
      if      (ADDRIN == ADDRHEX)   io_rdata = DBITS'(hex_q);
      else if (ADDRIN == ADDRLEDR)  io_rdata = DBITS'(ledr_q);
      else if (ADDRIN == ADDRLEDG)  io_rdata = DBITS'(ledg_q);
      else if (ADDRIN == ADDRKDATA) io_rdata = DBITS'(key_deb);
      else if (ADDRIN == ADDRKCTRL) io_rdata = ctrl_word(krdy_q, kovr_q, kie_q);
      else if (ADDRIN == ADDRSDATA) io_rdata = DBITS'(sw_deb);
      else if (ADDRIN == ADDRSCTRL) io_rdata = ctrl_word(srdy_q, sovr_q, sie_q);
   end

   // sel_io_q resets to 1 so DOUT reads the cleared I/O register out of reset.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         hex_q    <= 16'hBEEF;
         ledr_q   <= '0;
         ledg_q   <= '0;
         krdy_q   <= 1'b0;
         kovr_q   <= 1'b0;
         kie_q    <= 1'b0;
         srdy_q   <= 1'b0;
         sovr_q   <= 1'b0;
         sie_q    <= 1'b0;
         io_rd_q  <= '0;
         sel_io_q <= 1'b1;
         irq_q    <= 1'b0;
      end else begin
         if (wr_hex)  hex_q  <= DIN[15:0];
         if (wr_ledr) ledr_q <= DIN[NUMLEDR-1:0];
         if (wr_ledg) ledg_q <= DIN[NUMLEDG-1:0];
         krdy_q   <= krdy_d;
         kovr_q   <= kovr_d;
         kie_q    <= kie_d;
         srdy_q   <= srdy_d;
         sovr_q   <= sovr_d;
         sie_q    <= sie_d;
         io_rd_q  <= io_rdata;
         sel_io_q <= is_io;
         irq_q    <= (krdy_q & kie_q) | (srdy_q & sie_q);
      end
   end

   assign DOUT = sel_io_q ? io_rd_q : mem_rd_q;
   assign LEDR = ledr_q;
   assign LEDG = ledg_q;
   assign IRQ  = irq_q;
   assign HEX0 = seven_seg(hex_q[3:0]);
   assign HEX1 = seven_seg(hex_q[7:4]);
   assign HEX2 = seven_seg(hex_q[11:8]);
   assign HEX3 = seven_seg(hex_q[15:12]);

endmodule

// File: tb/tb_dmem_io_ctrl.sv
`timescale 1ns/1ps
// Bench for dmem_io_ctrl with DEBOUNCE=4: table of memory/I-O bus vectors
// plus hand-written KEY/SW debounce and interrupt sequences.
module tb_dmem_io_ctrl;

   localparam logic [31:0] A_HEX   = 32'hFFFF0000;
   localparam logic [31:0] A_LEDR  = 32'hFFFF0020;
   localparam logic [31:0] A_LEDG  = 32'hFFFF0040;
   localparam logic [31:0] A_KDATA = 32'hFFFF0100;
   localparam logic [31:0] A_KCTRL = 32'hFFFF0104;
   localparam logic [31:0] A_SDATA = 32'hFFFF0120;
   localparam logic [31:0] A_SCTRL = 32'hFFFF0124;

   logic        CLK = 1'b0;
   logic        RESET;
   logic [31:0] ADDRIN, DIN, DOUT;
   logic        WE;
   logic [3:0]  BE;
   logic [9:0]  SW, LEDR;
   logic [3:0]  KEY;
   logic [7:0]  LEDG;
   logic [6:0]  HEX0, HEX1, HEX2, HEX3;
   logic        IRQ;

   dmem_io_ctrl #(.DEBOUNCE(4)) dut (
      .CLK(CLK), .RESET(RESET), .ADDRIN(ADDRIN), .DIN(DIN), .WE(WE), .BE(BE),
      .DOUT(DOUT), .SW(SW), .KEY(KEY), .LEDR(LEDR), .LEDG(LEDG),
      .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .IRQ(IRQ)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      logic [31:0] addr;
      logic [31:0] din;
      logic        we;
      logic [3:0]  be;
      logic        rd;
      logic [31:0] exp;
      string       name;
   } vec_t;

   typedef struct {
      int          due;
      logic [31:0] exp;
      string       name;
   } sb_t;

   sb_t  sbq[$];
   int   cyc_n   = 0;
   int   n_tests = 0;
   int   n_fail  = 0;
   logic [6:0] seg [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Scoreboard: read results are due on the edge after the address is driven.
   initial forever begin
      sb_t e;
      @(posedge CLK);
      cyc_n++;
      #1;
      while (sbq.size() > 0 && sbq[0].due <= cyc_n) begin
         e = sbq.pop_front();
         chk(e.name, DOUT, e.exp);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout, expected finish");
      $fatal(1, "timeout");
   end

   task automatic bus(input logic [31:0] a, input logic [31:0] d, input logic w,
                      input logic [3:0] b, input logic rd, input logic [31:0] e,
                      input string nm);
      sb_t s;
      ADDRIN = a;
      DIN    = d;
      WE     = w;
      BE     = b;
      if (rd) begin
         s.due  = cyc_n + 1;
         s.exp  = e;
         s.name = nm;
         sbq.push_back(s);
      end
      @(posedge CLK);
      @(negedge CLK);
      WE = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] e, input string nm);
      bus(a, 32'h0, 1'b0, 4'h0, 1'b1, e, nm);
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus(a, d, 1'b1, 4'hF, 1'b0, 32'h0, "");
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) bus(32'h0, 32'h0, 1'b0, 4'h0, 1'b0, 32'h0, "");
   endtask

   vec_t vt[16];

   initial begin
      seg[0]  = 7'h40; seg[1]  = 7'h79; seg[2]  = 7'h24; seg[3]  = 7'h30;
      seg[4]  = 7'h19; seg[5]  = 7'h12; seg[6]  = 7'h02; seg[7]  = 7'h78;
      seg[8]  = 7'h00; seg[9]  = 7'h10; seg[10] = 7'h08; seg[11] = 7'h03;
      seg[12] = 7'h46; seg[13] = 7'h21; seg[14] = 7'h06; seg[15] = 7'h0E;

      vt[0]  = '{32'h00000010, 32'h11223344, 1'b1, 4'b1111, 1'b0, 32'h0,        "wr_full"};
      vt[1]  = '{32'h00000010, 32'hAABBCCDD, 1'b1, 4'b0101, 1'b0, 32'h0,        "wr_be0101"};
      vt[2]  = '{32'h00000010, 32'h0,        1'b0, 4'b0000, 1'b1, 32'h11BB33DD, "rd_be_merge"};
      vt[3]  = '{32'h00002010, 32'h0,        1'b0, 4'b0000, 1'b1, 32'h11BB33DD, "rd_alias"};
      vt[4]  = '{32'h00000014, 32'hCAFEF00D, 1'b1, 4'b1111, 1'b0, 32'h0,        "wr_14"};
      vt[5]  = '{32'h00000014, 32'h00000000, 1'b1, 4'b0000, 1'b0, 32'h0,        "wr_be0"};
      vt[6]  = '{32'h00000014, 32'h0,        1'b0, 4'b0000, 1'b1, 32'hCAFEF00D, "rd_be0_nochange"};
      vt[7]  = '{32'h00000014, 32'h12345678, 1'b1, 4'b1111, 1'b1, 32'hCAFEF00D, "rd_during_wr_old"};
      vt[8]  = '{32'h00000014, 32'h0,        1'b0, 4'b0000, 1'b1, 32'h12345678, "rd_after_wr"};
      vt[9]  = '{32'h00000200, 32'h5A5A5A5A, 1'b1, 4'b1111, 1'b0, 32'h0,        "wr_200"};
      vt[10] = '{32'hFFFF0200, 32'hFFFFFFFF, 1'b1, 4'b1111, 1'b0, 32'h0,        "wr_io_undec"};
      vt[11] = '{32'h00000200, 32'h0,        1'b0, 4'b0000, 1'b1, 32'h5A5A5A5A, "rd_200_kept"};
      vt[12] = '{32'hFFFF0200, 32'h0,        1'b0, 4'b0000, 1'b1, 32'h00000000, "rd_io_undec"};
      vt[13] = '{A_KDATA,      32'h0,        1'b0, 4'b0000, 1'b1, 32'h00000000, "rd_kdata0"};
      vt[14] = '{A_KCTRL,      32'h0,        1'b0, 4'b0000, 1'b1, 32'h00000000, "rd_kctrl0"};
      vt[15] = '{A_SCTRL,      32'h0,        1'b0, 4'b0000, 1'b1, 32'h00000000, "rd_sctrl0"};

      RESET  = 1'b1;
      ADDRIN = 32'h0;
      DIN    = 32'h0;
      WE     = 1'b0;
      BE     = 4'h0;
      SW     = '0;
      KEY    = '1;
      repeat (3) @(negedge CLK);
      chk("rst_hex0", {25'b0, HEX0}, {25'b0, seg[15]});
      chk("rst_hex1", {25'b0, HEX1}, {25'b0, seg[14]});
      chk("rst_hex2", {25'b0, HEX2}, {25'b0, seg[14]});
      chk("rst_hex3", {25'b0, HEX3}, {25'b0, seg[11]});
      chk("rst_ledr", {22'b0, LEDR}, 32'h0);
      chk("rst_ledg", {24'b0, LEDG}, 32'h0);
      chk("rst_irq",  {31'b0, IRQ},  32'h0);
      chk("rst_dout", DOUT,          32'h0);
      RESET = 1'b0;
      @(negedge CLK);

      for (int i = 0; i < 16; i++)
         bus(vt[i].addr, vt[i].din, vt[i].we, vt[i].be, vt[i].rd, vt[i].exp, vt[i].name);

      // LED / HEX writes ignore BE and truncate DIN
      bus(A_LEDR, 32'hFFFFF155, 1'b1, 4'b0000, 1'b0, 32'h0, "");
      chk("ledr", {22'b0, LEDR}, 32'h155);
      wr(A_LEDG, 32'h123456A5);
      chk("ledg", {24'b0, LEDG}, 32'hA5);
      wr(A_HEX, 32'h1234C0DE);
      chk("hex0", {25'b0, HEX0}, {25'b0, seg[14]});
      chk("hex1", {25'b0, HEX1}, {25'b0, seg[13]});
      chk("hex2", {25'b0, HEX2}, {25'b0, seg[0]});
      chk("hex3", {25'b0, HEX3}, {25'b0, seg[12]});
      rd(A_HEX, 32'h0000C0DE, "rd_hex");

      // 3-cycle KEY glitch is rejected
      KEY[1] = 1'b0;
      idle(3);
      KEY[1] = 1'b1;
      idle(8);
      rd(A_KDATA, 32'h0, "glitch_kdata");
      rd(A_KCTRL, 32'h0, "glitch_kctrl");

      // held press: debounced value lands on the 6th edge
      KEY[1] = 1'b0;
      idle(5);
      rd(A_KDATA, 32'h0, "kdata_edge5");
      rd(A_KDATA, 32'h2, "kdata_edge6");
      rd(A_KCTRL, 32'h1, "kctrl_rdy");
      KEY[1] = 1'b1;
      idle(8);
      rd(A_KCTRL, 32'h1, "kctrl_release_no_event");
      rd(A_KDATA, 32'h0, "kdata_released");
      KEY[1] = 1'b0;
      idle(8);
      rd(A_KCTRL, 32'h5, "kctrl_ovr");

      // clear + enable, then IRQ follows RDY by one cycle
      wr(A_KCTRL, 32'h100);
      rd(A_KCTRL, 32'h100, "kctrl_cleared");
      chk("irq_idle", {31'b0, IRQ}, 32'h0);
      KEY[1] = 1'b1;
      idle(8);
      KEY[1] = 1'b0;
      idle(6);
      chk("irq_pre", {31'b0, IRQ}, 32'h0);
      idle(1);
      chk("irq_rise", {31'b0, IRQ}, 32'h1);
      rd(A_KCTRL, 32'h101, "kctrl_rdy_ie");
      wr(A_KCTRL, 32'h100);
      chk("irq_hold", {31'b0, IRQ}, 32'h1);
      idle(1);
      chk("irq_fall", {31'b0, IRQ}, 32'h0);
      KEY[1] = 1'b1;
      idle(8);

      // switches: coincident clear and event
      SW[3] = 1'b1;
      idle(8);
      rd(A_SCTRL, 32'h1, "sctrl_rdy");
      rd(A_SDATA, 32'h8, "sdata_8");
      SW[0] = 1'b1;
      idle(5);
      wr(A_SCTRL, 32'h0);
      rd(A_SCTRL, 32'h5, "sctrl_coincide");
      rd(A_SDATA, 32'h9, "sdata_9");
      wr(A_SCTRL, 32'h0);
      rd(A_SCTRL, 32'h0, "sctrl_clear");
      SW[3] = 1'b0;
      idle(8);
      rd(A_SCTRL, 32'h1, "sctrl_fall_event");
      wr(A_SCTRL, 32'h101);
      chk("irq_sw_pre", {31'b0, IRQ}, 32'h0);
      idle(1);
      chk("irq_sw", {31'b0, IRQ}, 32'h1);
      rd(A_SCTRL, 32'h101, "sctrl_keep_ie");
      wr(A_SCTRL, 32'h0);
      idle(1);
      chk("irq_sw_fall", {31'b0, IRQ}, 32'h0);

      idle(2);
      chk("sb_drained", sbq.size(), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
